pipelined_adder: RTL

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface. It generalises the 32-bit combinational ripple adder: configurable width, a configurable number of carry-propagating pipeline stages, an add/subtract mode and overflow detection. It sits between operand producers and any consumer that may apply backpressure, for example an ALU writeback or an accumulator.

---
 rtl/pipelined_adder_pkg.sv | 16 +
 rtl/pipelined_adder_slice.sv | 27 ++
 rtl/pipelined_adder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared arithmetic definitions for the pipelined adder/subtractor.
// Holds the default width, the full-adder carry and the stage-count sanity check.
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (c & (x ^ y));
    endfunction

    // True when the width can be split into equal chunks, one per stage.
    function automatic bit stages_divide(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational CW-bit ripple-carry adder; one instance per pipeline stage.
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    logic [CW:0] ripple;

    always_comb begin
        ripple    = '0;
        s         = '0;
        ripple[0] = cin;
        for (int i = 0; i < CW; i++) begin
            s[i]        = a[i] ^ b[i] ^ ripple[i];
            ripple[i+1] = fa_carry(a[i], b[i], ripple[i]);
        end
        cout = ripple[CW];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshaking.
// Each stage resolves one CW-bit chunk and forwards operands plus partial sum.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!stages_divide(WIDTH, STAGES)) begin : g_bad_stages
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] stage_v;
    logic [STAGES-1:0] stage_c;
    logic [WIDTH-1:0]  stage_a [STAGES];
    logic [WIDTH-1:0]  stage_b [STAGES];
    logic [WIDTH-1:0]  stage_s [STAGES];

    // Subtraction is a + ~b + ~borrow_in, so the whole chain only ever adds.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~carry_in : carry_in;

    // A slot can load when it is empty or its occupant moves on this edge.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !stage_v[k] || rdy[k+1];
        end
    end

    assign in_ready = !rst && rdy[0];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] src_a, src_b, src_s, s_next;
        logic             src_c, src_v;
        logic [CW-1:0]    chunk_s;
        logic             chunk_c;
        logic             v_reg, c_reg;
        logic [WIDTH-1:0] a_reg, b_reg, s_reg;

        if (gi == 0) begin : g_head
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = c0;
            assign src_s = '0;
            assign src_v = in_valid;
        end else begin : g_tail
            assign src_a = stage_a[gi-1];
            assign src_b = stage_b[gi-1];
            assign src_c = stage_c[gi-1];
            assign src_s = stage_s[gi-1];
            assign src_v = stage_v[gi-1];
        end

        adder_slice #(.CW(CW)) u_slice (
            .a    (src_a[gi*CW +: CW]),
            .b    (src_b[gi*CW +: CW]),
            .cin  (src_c),
            .s    (chunk_s),
            .cout (chunk_c)
        );

        always_comb begin
            s_next               = src_s;
            s_next[gi*CW +: CW]  = chunk_s;
        end

        // Data only loads with a valid beat so a stalled or idle output never toggles.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_reg <= 1'b0;
                c_reg <= 1'b0;
                a_reg <= '0;
                b_reg <= '0;
                s_reg <= '0;
            end else if (rdy[gi]) begin
                v_reg <= src_v;
                if (src_v) begin
                    c_reg <= chunk_c;
                    a_reg <= src_a;
                    b_reg <= src_b;
                    s_reg <= s_next;
                end
            end
        end

        assign stage_v[gi] = v_reg;
        assign stage_c[gi] = c_reg;
        assign stage_a[gi] = a_reg;
        assign stage_b[gi] = b_reg;
        assign stage_s[gi] = s_reg;
    end

    assign out_valid = stage_v[LAST];
    assign sum       = stage_s[LAST];
    assign carry_out = stage_c[LAST];
    assign overflow  = (stage_a[LAST][WIDTH-1] == stage_b[LAST][WIDTH-1]) &&
                       (stage_s[LAST][WIDTH-1] != stage_a[LAST][WIDTH-1]);

endmodule
